char_layer: RTL and testbench

CHAR_LAYER -- requirements
Module: char_layer

---
 rtl/char_layer.sv | 152 +++++++++++++++
 tb/tb_char_layer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/char_layer.sv
// Character (tile) layer: fetches one 8x8 tile row per 8 pixels through a small
// VRAM -> ROM fetch FSM, then shifts two bitplanes out at the pixel rate.
module char_layer #(
   parameter int unsigned ROM_LAT = 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce_pix,
   input  logic [8:0]  hcnt,
   input  logic [8:0]  vcnt,
   output logic [9:0]  vram_addr,
   input  logic [7:0]  vram_code,
   input  logic [7:0]  vram_attr,
   output logic [12:0] char_rom_addr,
   input  logic [7:0]  char_data1,
   input  logic [7:0]  char_data2,
   output logic [5:0]  pix_out,
   output logic        pix_opaque,
   output logic        overrun
);

   typedef enum logic [2:0] {StIdle, StMap, StCode, StRomw, StLoad} state_e;

   state_e      state_q, state_d;
   logic [9:0]  vram_addr_q, vram_addr_d;
   logic [12:0] rom_addr_q, rom_addr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  attr_q, attr_d;
   logic [7:0]  hold1_q, hold1_d, hold2_q, hold2_d;
   logic [3:0]  hold_pal_q, hold_pal_d;
   logic [7:0]  sh1_q, sh1_d, sh2_q, sh2_d;
   logic [3:0]  pal_q, pal_d;
   logic [5:0]  pix_q, pix_d;
   logic        opaque_q, opaque_d;
   logic        overrun_q, overrun_d;
   logic        trigger;

   // Only 256-pixel maps and 256-line tile rows exist; bit 8 of the counters is unused.
   logic unused_bits;
   assign unused_bits = ^{hcnt[8], vcnt[8]};

   assign trigger = ce_pix && (hcnt[2:0] == 3'd0);

   function automatic logic [7:0] bit_rev(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   // Fetch FSM: next state, address generation and holding-register loads.
   always_comb begin
      state_d     = state_q;
      vram_addr_d = vram_addr_q;
      rom_addr_d  = rom_addr_q;
      cnt_d       = cnt_q;
      attr_d      = attr_q;
      hold1_d     = hold1_q;
      hold2_d     = hold2_q;
      hold_pal_d  = hold_pal_q;
      // A trigger that finds the FSM busy is dropped; the running fetch continues.
      overrun_d   = overrun_q | (trigger && (state_q != StIdle));
      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               vram_addr_d = {vcnt[7:3], hcnt[7:3] + 5'd1};
               state_d     = StMap;
            end
         end
         StMap: state_d = StCode;
         StCode: begin
            attr_d     = vram_attr;
            rom_addr_d = {vram_attr[5:4], vram_code, vcnt[2:0] ^ {3{vram_attr[7]}}};
            cnt_d      = 2'(ROM_LAT);
            state_d    = StRomw;
         end
         StRomw: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) state_d = StLoad;
         end
         StLoad: begin
            hold1_d    = attr_q[6] ? bit_rev(char_data1) : char_data1;
            hold2_d    = attr_q[6] ? bit_rev(char_data2) : char_data2;
            hold_pal_d = attr_q[3:0];
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Pixel pipe: emit current MSBs, then reload on the last pixel of a tile or shift.
   always_comb begin
      sh1_d    = sh1_q;
      sh2_d    = sh2_q;
      pal_d    = pal_q;
      pix_d    = pix_q;
      opaque_d = opaque_q;
      if (ce_pix) begin
         pix_d    = {pal_q, sh2_q[7], sh1_q[7]};
         opaque_d = sh2_q[7] | sh1_q[7];
         if (hcnt[2:0] == 3'd7) begin
            sh1_d = hold1_q;
            sh2_d = hold2_q;
            pal_d = hold_pal_q;
         end else begin
            sh1_d = {sh1_q[6:0], 1'b0};
            sh2_d = {sh2_q[6:0], 1'b0};
         end
      end
   end

   // State registers; reset abandons any fetch in progress.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         vram_addr_q <= '0;
         rom_addr_q  <= '0;
         cnt_q       <= '0;
         attr_q      <= '0;
         hold1_q     <= '0;
         hold2_q     <= '0;
         hold_pal_q  <= '0;
         sh1_q       <= '0;
         sh2_q       <= '0;
         pal_q       <= '0;
         pix_q       <= '0;
         opaque_q    <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         vram_addr_q <= vram_addr_d;
         rom_addr_q  <= rom_addr_d;
         cnt_q       <= cnt_d;
         attr_q      <= attr_d;
         hold1_q     <= hold1_d;
         hold2_q     <= hold2_d;
         hold_pal_q  <= hold_pal_d;
         sh1_q       <= sh1_d;
         sh2_q       <= sh2_d;
         pal_q       <= pal_d;
         pix_q       <= pix_d;
         opaque_q    <= opaque_d;
         overrun_q   <= overrun_d;
      end
   end

   assign vram_addr     = vram_addr_q;
   assign char_rom_addr = rom_addr_q;
   assign pix_out       = pix_q;
   assign pix_opaque    = opaque_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_char_layer.sv
// Bench for char_layer: two instances (ROM latency 1 and 2) share the video timing
// inputs; a table-driven scanline model gives the expected addresses and pixels.
module tb_char_layer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce_pix = 1'b0;
   logic [8:0]  hcnt = '0;
   logic [8:0]  vcnt = '0;

   logic [9:0]  va1, va2;
   logic [12:0] ra1, ra2;
   logic [7:0]  vc1, vt1, vc2, vt2;
   logic [7:0]  d1_1, d2_1, d1_2a, d2_2a, d1_2, d2_2;
   logic [5:0]  px1, px2;
   logic        op1, op2, ov1, ov2;

   logic [7:0]  vcode [1024];
   logic [7:0]  vattr [1024];
   logic [7:0]  rom1 [8192];
   logic [7:0]  rom2 [8192];

   int n_cmp = 0;
   int n_fail = 0;
   int valid_from = 8;

   always #5 clk = ~clk;

   char_layer #(.ROM_LAT(1)) u1 (
      .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt),
      .vram_addr(va1), .vram_code(vc1), .vram_attr(vt1), .char_rom_addr(ra1),
      .char_data1(d1_1), .char_data2(d2_1), .pix_out(px1), .pix_opaque(op1),
      .overrun(ov1)
   );

   char_layer #(.ROM_LAT(2)) u2 (
      .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt),
      .vram_addr(va2), .vram_code(vc2), .vram_attr(vt2), .char_rom_addr(ra2),
      .char_data1(d1_2), .char_data2(d2_2), .pix_out(px2), .pix_opaque(op2),
      .overrun(ov2)
   );

   // Memory models: VRAM one cycle, ROM one or two cycles after the address.
   always @(posedge clk) begin
      vc1   <= vcode[va1];
      vt1   <= vattr[va1];
      vc2   <= vcode[va2];
      vt2   <= vattr[va2];
      d1_1  <= rom1[ra1];
      d2_1  <= rom2[ra1];
      d1_2a <= rom1[ra2];
      d2_2a <= rom2[ra2];
      d1_2  <= d1_2a;
      d2_2  <= d2_2a;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Tile map entry for column col on the current line.
   function automatic int map_index(input int col);
      return ((int'(vcnt) / 8) % 32) * 32 + (col % 32);
   endfunction

   function automatic int rom_index(input int col);
      int a, at, row;
      a   = map_index(col);
      at  = int'(vattr[a]);
      row = (int'(vcnt) % 8) ^ (((at / 128) % 2 == 1) ? 7 : 0);
      return ((at / 16) % 4) * 2048 + int'(vcode[a]) * 8 + row;
   endfunction

   // Screen pixel h: tile column (h/8) mod 32, pixel h mod 8 within it.
   function automatic int exp_pix(input int h);
      int col, a, at, ra, k, b, p0, p1;
      col = (h / 8) % 32;
      a   = map_index(col);
      at  = int'(vattr[a]);
      ra  = rom_index(col);
      k   = h % 8;
      b   = ((at / 64) % 2 == 1) ? k : 7 - k;
      p0  = (int'(rom1[ra]) >> b) & 1;
      p1  = (int'(rom2[ra]) >> b) & 1;
      return (at % 16) * 4 + p1 * 2 + p0;
   endfunction

   // One pixel period (8 clocks), entered and left at a falling edge.
   task automatic pixel(input int h, input bit chk);
      int e, ea, er;
      hcnt   = 9'(h);
      ce_pix = 1'b1;
      @(negedge clk);
      ce_pix = 1'b0;
      e  = (h < valid_from) ? 0 : exp_pix(h);
      ea = map_index(h / 8 + 1);
      er = rom_index(h / 8 + 1);
      if (chk) begin
         check("pix1", 16'(px1), 16'(e));
         check("pix2", 16'(px2), 16'(e));
         check("opq1", 16'(op1), 16'(e % 4 != 0));
         check("opq2", 16'(op2), 16'(e % 4 != 0));
         if (h % 8 == 0) begin
            check("vaddr1", 16'(va1), 16'(ea));
            check("vaddr2", 16'(va2), 16'(ea));
         end
      end
      repeat (2) @(negedge clk);
      if (chk && h % 8 == 0) begin
         check("raddr1", 16'(ra1), 16'(er));
         check("raddr2", 16'(ra2), 16'(er));
      end
      repeat (5) @(negedge clk);
      if (chk && h % 8 == 0) begin
         check("vhold1", 16'(va1), 16'(ea));
         check("rhold2", 16'(ra2), 16'(er));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b1;
      ce_pix = 1'b0;
      @(negedge clk);
      check("rst_pix1", 16'(px1), 16'h0);
      check("rst_ovr2", 16'(ov2), 16'h0);
      check("rst_va1", 16'(va1), 16'h0);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_line(input int last_h);
      valid_from = 8;
      for (int h = 0; h <= last_h; h++) pixel(h, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         vcode[i] = 8'($urandom);
         vattr[i] = 8'($urandom);
      end
      for (int i = 0; i < 8192; i++) begin
         rom1[i] = 8'($urandom);
         rom2[i] = 8'($urandom);
      end

      // Basic fetch: line 10, column 1 tile 0x41 with palette 5.
      repeat (2) @(negedge clk);
      do_reset();
      vcnt = 9'd10;
      vcode[10'h021] = 8'h41;
      vattr[10'h021] = 8'h05;
      rom1[13'h020A] = 8'hF0;
      rom2[13'h020A] = 8'h0F;
      run_line(15);
      check("ovr_clear1", 16'(ov1), 16'h0);

      // Both flips: row 1 -> 6, single set pixel lands in the last column.
      do_reset();
      vcnt = 9'd9;
      vcode[10'h021] = 8'h12;
      vattr[10'h021] = 8'hC0;
      rom1[13'h0096] = 8'h80;
      rom2[13'h0096] = 8'h00;
      run_line(15);

      // Random full lines including the column 31 -> 0 wrap past hcnt 255.
      for (int l = 0; l < 4; l++) begin
         do_reset();
         vcnt = 9'($urandom_range(0, 511));
         run_line(263);
         check("ovr_line2", 16'(ov2), 16'h0);
      end

      // Two triggers two clocks apart: second is dropped, first lands intact.
      do_reset();
      vcnt = 9'($urandom_range(0, 255));
      valid_from = 8;
      hcnt   = 9'd0;
      ce_pix = 1'b1;
      @(negedge clk);
      ce_pix = 1'b0;
      @(negedge clk);
      ce_pix = 1'b1;
      @(negedge clk);
      ce_pix = 1'b0;
      check("ovr_set1", 16'(ov1), 16'h1);
      check("ovr_set2", 16'(ov2), 16'h1);
      repeat (5) @(negedge clk);
      for (int h = 1; h <= 15; h++) pixel(h, 1'b1);
      check("ovr_sticky1", 16'(ov1), 16'h1);
      check("ovr_sticky2", 16'(ov2), 16'h1);

      // Reset while the fetch sits in the ROM wait; later fetches recover.
      do_reset();
      vcnt = 9'($urandom_range(0, 255));
      valid_from = 8;
      for (int h = 0; h <= 15; h++) pixel(h, 1'b1);
      hcnt   = 9'd16;
      ce_pix = 1'b1;
      @(negedge clk);
      ce_pix = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_va2", 16'(va2), 16'h0);
      check("mid_ra2", 16'(ra2), 16'h0);
      check("mid_px2", 16'(px2), 16'h0);
      check("mid_op2", 16'(op2), 16'h0);
      check("mid_ra1", 16'(ra1), 16'h0);
      check("mid_px1", 16'(px1), 16'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      valid_from = 32;
      for (int h = 17; h <= 39; h++) pixel(h, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
